// File: rtl/retire_sequencer_if.sv
// Retire sequencer bus: ROB head, RRAT ports, free list, recovery.
// master = retire_sequencer, slave = surrounding pipeline.
interface retire_sequencer_if #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 35
);
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
  localparam int LOG_ARCH = $clog2(NUM_ARCH_REGS);

  logic                Head_valid_IN;
  logic                Head_done_IN;
  logic                Head_exception_IN;
  logic                Head_has_dest_IN;
  logic [LOG_ARCH-1:0] Head_arch_IN;
  logic [LOG_PHYS-1:0] Head_phys_IN;
  logic [LOG_PHYS-1:0] Head_old_phys_IN;
  logic                Retire_OUT;
  logic                RRAT_write_OUT;
  logic [LOG_ARCH-1:0] RRAT_arch_OUT;
  logic [LOG_PHYS-1:0] RRAT_phys_OUT;
  logic [LOG_ARCH-1:0] RRAT_rd_arch_OUT;
  logic [LOG_PHYS-1:0] RRAT_rd_phys_IN;
  logic                Free_valid_OUT;
  logic [LOG_PHYS-1:0] Free_phys_OUT;
  logic                Free_ready_IN;
  logic                Flush_OUT;
  logic                Recover_write_OUT;
  logic [LOG_ARCH-1:0] Recover_arch_OUT;
  logic [LOG_PHYS-1:0] Recover_phys_OUT;
  logic                Busy_OUT;
  logic [31:0]         Retired_cnt_OUT;
  logic [31:0]         Flush_cnt_OUT;

  modport master (
    input  Head_valid_IN, Head_done_IN, Head_exception_IN,
    input  Head_has_dest_IN, Head_arch_IN, Head_phys_IN,
    input  Head_old_phys_IN, RRAT_rd_phys_IN, Free_ready_IN,
    output Retire_OUT, RRAT_write_OUT, RRAT_arch_OUT,
    output RRAT_phys_OUT, RRAT_rd_arch_OUT, Free_valid_OUT,
    output Free_phys_OUT, Flush_OUT, Recover_write_OUT,
    output Recover_arch_OUT, Recover_phys_OUT, Busy_OUT,
    output Retired_cnt_OUT, Flush_cnt_OUT
  );

  modport slave (
    output Head_valid_IN, Head_done_IN, Head_exception_IN,
    output Head_has_dest_IN, Head_arch_IN, Head_phys_IN,
    output Head_old_phys_IN, RRAT_rd_phys_IN, Free_ready_IN,
    input  Retire_OUT, RRAT_write_OUT, RRAT_arch_OUT,
    input  RRAT_phys_OUT, RRAT_rd_arch_OUT, Free_valid_OUT,
    input  Free_phys_OUT, Flush_OUT, Recover_write_OUT,
    input  Recover_arch_OUT, Recover_phys_OUT, Busy_OUT,
    input  Retired_cnt_OUT, Flush_cnt_OUT
  );
endinterface

// File: rtl/retire_sequencer.sv
// In-order retire into the RRAT, free-list return, flush + RAT recovery.
// Optional perf counters enabled by macro RETIRE_PERF_CNT_EN.
module retire_sequencer #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 35
) (
  input logic CLK,
  input logic RESET,
  retire_sequencer_if.master bus
);
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
  localparam int LOG_ARCH = $clog2(NUM_ARCH_REGS);
  localparam logic [LOG_ARCH-1:0] LAST =
    LOG_ARCH'(NUM_ARCH_REGS - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LOG_ARCH-1:0] rc_q, rc_d;
  logic                flush_q;
  logic                busy_q;
  logic                rec_q;

  logic run;
  logic head_ok;
  logic exc;
  logic go;

  assign run     = (state_q == RUN) & ~RESET;
  assign head_ok = bus.Head_valid_IN & bus.Head_done_IN;
  assign exc     = run & head_ok & bus.Head_exception_IN;
  assign go      = run & head_ok & ~bus.Head_exception_IN
                 & (~bus.Head_has_dest_IN | bus.Free_ready_IN);

  // Next-state and recovery-index logic
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    unique case (state_q)
      RUN: begin
        if (exc) state_d = FLUSH;
      end
      FLUSH: begin
        rc_d    = '0;
        state_d = RECOVER;
      end
      RECOVER: begin
        if (rc_q == LAST) begin
          rc_d    = '0;
          state_d = RUN;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      default: begin
        rc_d    = '0;
        state_d = RUN;
      end
    endcase
  end

  // FSM state, recovery index and state-decoded output flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      rc_q    <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      rec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      flush_q <= (state_d == FLUSH);
      busy_q  <= (state_d != RUN);
      rec_q   <= (state_d == RECOVER);
    end
  end

  assign bus.Retire_OUT     = go;
  assign bus.RRAT_write_OUT = go & bus.Head_has_dest_IN;
  assign bus.Free_valid_OUT = go & bus.Head_has_dest_IN;
  assign bus.RRAT_arch_OUT  =
    go ? bus.Head_arch_IN : '0;
  assign bus.RRAT_phys_OUT  =
    go ? bus.Head_phys_IN : '0;
  assign bus.Free_phys_OUT  =
    go ? bus.Head_old_phys_IN : '0;

  logic rec_on;
  assign rec_on = rec_q & ~RESET;

  assign bus.Flush_OUT         = flush_q & ~RESET;
  assign bus.Busy_OUT          = busy_q & ~RESET;
  assign bus.Recover_write_OUT = rec_on;
  assign bus.RRAT_rd_arch_OUT  = rec_on ? rc_q : '0;
  assign bus.Recover_arch_OUT  = rec_on ? rc_q : '0;
  assign bus.Recover_phys_OUT  =
    rec_on ? bus.RRAT_rd_phys_IN : '0;

`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] ret_cnt_q;
  logic [31:0] fl_cnt_q;

  // Retire and flush event counters, wrapping
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ret_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      if (bus.Retire_OUT) ret_cnt_q <= ret_cnt_q + 32'd1;
      if (bus.Flush_OUT)  fl_cnt_q  <= fl_cnt_q + 32'd1;
    end
  end

  assign bus.Retired_cnt_OUT = RESET ? 32'd0 : ret_cnt_q;
  assign bus.Flush_cnt_OUT   = RESET ? 32'd0 : fl_cnt_q;
`else
  assign bus.Retired_cnt_OUT = 32'd0;
  assign bus.Flush_cnt_OUT   = 32'd0;
`endif

endmodule
